exec_mem_stage: RTL and testbench
=================================

Name: exec_mem_stage

Overview:
- Execute and memory stage of the rv32i single-cycle core: 32-bit ALU, 4 KiB byte-addressed data memory, store lane generation and load byte extraction.
- Sits between the register file / sign_extend outputs and the write-back mux.
- Also has a bulk-initialisation write port, active before the core runs, and a combinational debug read port.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width.
- ADDR_WIDTH, 12, byte address width of the data memory (1024 words).

Ports:
- clk  in  1  clock; memory writes happen on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_ctrl  in  4  ALU operation code.
- alu_src  in  1  0: operand B = src2; 1: operand B = sign_ext.
- src1  in  32  rs1 value.
- src2  in  32  rs2 value; also the store data.
- sign_ext  in  32  sign-extended immediate.
- func3  in  3  instruction func3; selects load/store width.
- mem_read  in  1  load enable.
- mem_write  in  1  store enable.
- init_done  in  1  0: the init port drives the memory write port; 1: the core drives it.
- init_w_addr  in  12  init byte address.
- init_w_dat  in  32  init data.
- init_w_enb  in  1  init write enable.
- init_byte_enb  in  4  init byte lanes.
- debug_addr  in  12  debug byte address.
- results  out  32  ALU result; also the memory address.
- zero  out  1  high when results == 0.
- res_last_bit  out  1  equals results[0].
- wb_data  out  32  extended load data.
- valid  out  1  load data valid.
- debug_data  out  32  word at debug_addr[11:2].

Behaviour:
- ALU is combinational. Operand B is src2 or sign_ext per alu_src.
- ALU codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT (signed), 1001 SLTU.
- Shifts use B[4:0]. Any other code gives results = 0. Arithmetic wraps modulo 2^32.
- Lane mask from func3[1:0] and results[1:0]:
  - 00 (byte): one-hot lane at the offset.
  - 01 (half): 0011 at offset 0, 1100 at offset 2; misaligned offsets give 0000.
  - 10 (word): 1111 at offset 0; otherwise 0000.
  - 11: 0000.
- Memory words are indexed by address[11:2]; writes are byte-masked on the rising clk edge.
- Write sources:
  - init_done = 0: init_* signals.
  - init_done = 1: address {results[11:2],00}, enable mem_write, lane mask as above.
  - Store data is src2 replicated into lanes: byte replicated ×4, half ×2, word as is.
  - A write with lane mask 0000 changes nothing.
- Read is combinational (zero-cycle latency), as needed for single-cycle loads.
  - Raw word = mem[results[11:2]] when mem_read = 1, otherwise 0.
  - Address bits above 11 are ignored (wrap within 4 KiB).
- Load extraction:
  - func3 000 LB, 100 LBU: selected byte.
  - 001 LH, 101 LHU: selected half.
  - 010 LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - valid = mem_read AND lane mask nonzero AND func3 ∈ {000,001,010,100,101}.
  - When valid = 0, wb_data = 0.
- debug_data is combinational and unaffected by mem_read.
- Reset:
  - While rst = 0, all writes are blocked.
  - While rst = 0, wb_data = 0 and valid = 0.
  - Memory contents are not cleared by reset.
  - ALU outputs stay purely combinational.
- Reset asserted mid-write: the write is suppressed if rst is low at the clock edge.
- Simultaneous read and write to the same word: the read returns the old contents until the edge, then the new contents.

Decomposition:
- Shared package (rv32i_params / rv32i_control includes): DATA_WIDTH, ALU code constants, load/store func3 constants.
- One natural sub-module: exec_alu (the combinational ALU).
- Memory array, lane logic and extraction are inline.

Test Plan:
- ALU: src1 = 5, sign_ext = 0xFFFFFFFF, alu_src = 1, ADD -> results 4, zero 0. SUB 3−3 -> 0, zero 1. SLT −1 < 1 -> 1, res_last_bit 1. SRA 0x80000000 >> 4 -> 0xF8000000.
- Init load: init_done = 0, write 0x1, 0x2, 0x3 to 0x0/0x4/0x8 with lanes 1111 -> debug_data at 0x4 = 0x00000002.
- Store/load word, init_done = 1:
  - src1 = 0, sign_ext = 0xC, ADD, mem_write = 1, func3 = 010, src2 = 1 -> after the edge, debug 0xC = 0x00000001.
  - Load at 0xC -> wb_data 0x00000001, valid 1.
- Byte and half:
  - Word 0x80FF7F01: LB at offset 3 -> 0xFFFFFF80; LBU -> 0x00000080; LH at offset 2 -> 0xFFFF80FF.
  - SB 0xAB at offset 1 -> word becomes 0x80FFAB01.
- Misaligned and illegal:
  - LW at 0x2 -> valid 0, wb_data 0.
  - SW at 0x2 -> memory unchanged.
  - func3 = 011 -> valid 0.
- Reset: rst = 0 with mem_write = 1 at the edge -> no write, valid 0. Release rst -> prior contents intact.

Source files
------------

// File: rtl/exec_mem_stage_pkg.sv
// Shared constants for the rv32i execute/memory stage: ALU op codes,
// load/store func3 encodings and the byte-lane mask helper.
package exec_mem_stage_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte lanes touched by an access of the given size at the given offset;
  // misaligned or unsupported sizes yield no lanes at all.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return (off == 2'd0) ? 4'b0011 : (off == 2'd2) ? 4'b1100 : 4'b0000;
      2'b10:   return (off == 2'd0) ? 4'b1111 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/exec_mem_stage_alu.sv
// Combinational 32-bit ALU for the rv32i execute stage.
module exec_alu
  import exec_mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] result
);

  logic [4:0] shamt;
  assign shamt = op_b[4:0];

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SLL:  result = op_a << shamt;
      ALU_SRL:  result = op_a >> shamt;
      ALU_SRA:  result = $signed(op_a) >>> shamt;
      ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/exec_mem_stage.sv
// rv32i execute + memory stage: ALU, 4 KiB byte-masked data memory with
// init/debug ports, store lane replication and load extraction.
module exec_mem_stage
  import exec_mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            alu_ctrl,
  input  logic                  alu_src,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [DATA_WIDTH-1:0] sign_ext,
  input  logic [2:0]            func3,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  init_done,
  input  logic [ADDR_WIDTH-1:0] init_w_addr,
  input  logic [DATA_WIDTH-1:0] init_w_dat,
  input  logic                  init_w_enb,
  input  logic [3:0]            init_byte_enb,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] results,
  output logic                  zero,
  output logic                  res_last_bit,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] debug_data
);

  localparam int unsigned IDX_W     = ADDR_WIDTH - 2;
  localparam int unsigned MEM_WORDS = 2 ** IDX_W;

  logic [DATA_WIDTH-1:0] op_b;
  assign op_b = alu_src ? sign_ext : src2;

  exec_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .alu_ctrl (alu_ctrl),
    .op_a     (src1),
    .op_b     (op_b),
    .result   (results)
  );

  assign zero         = (results == '0);
  assign res_last_bit = results[0];

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [IDX_W-1:0]      core_idx;
  logic [1:0]            core_off;
  logic [3:0]            core_mask;
  logic [DATA_WIDTH-1:0] st_data;
  logic [IDX_W-1:0]      wr_idx;
  logic [3:0]            wr_lanes;
  logic [DATA_WIDTH-1:0] wr_data;

  assign core_idx  = results[ADDR_WIDTH-1:2];
  assign core_off  = results[1:0];
  assign core_mask = lane_mask(func3[1:0], core_off);

  always_comb begin
    st_data = src2;
    case (func3[1:0])
      2'b00:   st_data = {4{src2[7:0]}};
      2'b01:   st_data = {2{src2[15:0]}};
      default: st_data = src2;
    endcase
  end

  always_comb begin
    if (init_done) begin
      wr_idx   = core_idx;
      wr_lanes = mem_write ? core_mask : 4'b0000;
      wr_data  = st_data;
    end else begin
      wr_idx   = init_w_addr[ADDR_WIDTH-1:2];
      wr_lanes = init_w_enb ? init_byte_enb : 4'b0000;
      wr_data  = init_w_dat;
    end
  end

  // Memory holds no reset value; rst only gates the write strobe, so sampling
  // it at the edge suppresses any write while reset is asserted.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (rst && wr_lanes[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  logic [DATA_WIDTH-1:0] raw_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  f3_legal;

  assign raw_word   = mem_read ? mem[core_idx] : '0;
  assign ld_byte    = raw_word[{core_off, 3'b000} +: 8];
  assign ld_half    = core_off[1] ? raw_word[31:16] : raw_word[15:0];
  assign f3_legal   = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
                      (func3 == F3_BU) || (func3 == F3_HU);
  assign valid      = rst && mem_read && (core_mask != 4'b0000) && f3_legal;
  assign debug_data = mem[debug_addr[ADDR_WIDTH-1:2]];

  always_comb begin
    wb_data = '0;
    if (valid) begin
      case (func3)
        F3_B:    wb_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
        F3_BU:   wb_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
        F3_H:    wb_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
        F3_HU:   wb_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
        default: wb_data = raw_word;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{results[DATA_WIDTH-1:ADDR_WIDTH], init_w_addr[1:0], debug_addr[1:0]};

endmodule

// File: tb/tb_exec_mem_stage.sv
// Scoreboard bench for exec_mem_stage: expectations queued at drive time,
// popped and compared once the combinational outputs have settled.
module tb_exec_mem_stage;
  import exec_mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alu_ctrl;
  logic        alu_src;
  logic [31:0] src1, src2, sign_ext;
  logic [2:0]  func3;
  logic        mem_read, mem_write, init_done;
  logic [11:0] init_w_addr;
  logic [31:0] init_w_dat;
  logic        init_w_enb;
  logic [3:0]  init_byte_enb;
  logic [11:0] debug_addr;
  logic [31:0] results, wb_data, debug_data;
  logic        zero, res_last_bit, valid;

  exec_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
    .src1(src1), .src2(src2), .sign_ext(sign_ext), .func3(func3),
    .mem_read(mem_read), .mem_write(mem_write), .init_done(init_done),
    .init_w_addr(init_w_addr), .init_w_dat(init_w_dat), .init_w_enb(init_w_enb),
    .init_byte_enb(init_byte_enb), .debug_addr(debug_addr),
    .results(results), .zero(zero), .res_last_bit(res_last_bit),
    .wb_data(wb_data), .valid(valid), .debug_data(debug_data)
  );

  always #5 clk = ~clk;

  typedef enum int {S_RES, S_ZERO, S_LAST, S_WB, S_VALID, S_DBG} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input sel_e sel, input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_entry_t e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        S_RES:   obs = results;
        S_ZERO:  obs = {31'b0, zero};
        S_LAST:  obs = {31'b0, res_last_bit};
        S_WB:    obs = wb_data;
        S_VALID: obs = {31'b0, valid};
        default: obs = debug_data;
      endcase
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  task automatic alu_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic use_imm);
    alu_ctrl = ctrl; src1 = a; src2 = b; sign_ext = imm; alu_src = use_imm;
  endtask

  task automatic mem_op(input logic [31:0] addr, input logic [2:0] f3, input logic rd,
                        input logic wr, input logic [31:0] data);
    alu_ctrl = ALU_ADD; src1 = addr; sign_ext = '0; alu_src = 1'b1;
    src2 = data; func3 = f3; mem_read = rd; mem_write = wr;
  endtask

  task automatic init_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    init_w_addr = addr; init_w_dat = data; init_w_enb = 1'b1; init_byte_enb = 4'b1111;
    @(posedge clk);
    #1 init_w_enb = 1'b0;
  endtask

  task automatic dbg(input logic [11:0] addr, input string tag, input logic [31:0] exp);
    debug_addr = addr;
    expect_out(S_DBG, tag, exp);
    drain();
  endtask

  task automatic load_chk(input logic [31:0] addr, input logic [2:0] f3, input string tag,
                          input logic [31:0] exp_wb, input logic exp_valid);
    @(negedge clk);
    mem_op(addr, f3, 1'b1, 1'b0, 32'h0);
    expect_out(S_WB, {tag, "_wb"}, exp_wb);
    expect_out(S_VALID, {tag, "_valid"}, {31'b0, exp_valid});
    drain();
  endtask

  task automatic store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data);
    @(negedge clk);
    mem_op(addr, f3, 1'b0, 1'b1, data);
    @(posedge clk);
    #1 mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b0; init_done = 1'b0; init_w_addr = '0; init_w_dat = '0; init_w_enb = 1'b0;
    init_byte_enb = '0; debug_addr = '0; func3 = F3_W; mem_read = 1'b1; mem_write = 1'b0;
    alu_op(ALU_ADD, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    expect_out(S_VALID, "rst_valid", 32'd0);
    expect_out(S_WB, "rst_wb", 32'd0);
    expect_out(S_RES, "rst_alu_add", 32'd4);
    drain();
    @(negedge clk); rst = 1'b1; mem_read = 1'b0;

    expect_out(S_RES, "add", 32'd4);
    expect_out(S_ZERO, "add_zero", 32'd0);
    drain();
    alu_op(ALU_SUB, 32'd3, 32'd3, 32'd0, 1'b0);
    expect_out(S_RES, "sub", 32'd0);
    expect_out(S_ZERO, "sub_zero", 32'd1);
    drain();
    alu_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    expect_out(S_RES, "slt", 32'd1);
    expect_out(S_LAST, "slt_last", 32'd1);
    drain();
    alu_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    expect_out(S_RES, "sltu", 32'd0);
    drain();
    alu_op(ALU_SRA, 32'h8000_0000, 32'd4, 32'd0, 1'b0);
    expect_out(S_RES, "sra", 32'hF800_0000);
    drain();
    alu_op(ALU_SRL, 32'h8000_0000, 32'd36, 32'd0, 1'b0);
    expect_out(S_RES, "srl_b40", 32'h0800_0000);
    drain();
    alu_op(ALU_SLL, 32'h0000_0003, 32'd0, 32'd31, 1'b1);
    expect_out(S_RES, "sll", 32'h8000_0000);
    drain();
    alu_op(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0);
    expect_out(S_RES, "and", 32'h00F0_1200);
    drain();
    alu_op(ALU_OR, 32'hF000_0001, 32'h0000_0F00, 32'd0, 1'b0);
    expect_out(S_RES, "or", 32'hF000_0F01);
    drain();
    alu_op(ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 1'b0);
    expect_out(S_RES, "xor", 32'hF0F0_0F0F);
    drain();
    alu_op(4'b1111, 32'h1234_5678, 32'h1, 32'd0, 1'b0);
    expect_out(S_RES, "illegal_op", 32'd0);
    expect_out(S_ZERO, "illegal_zero", 32'd1);
    drain();

    mem_write = 1'b1;  // ignored while the init port owns the memory
    init_write(12'h000, 32'h1);
    init_write(12'h004, 32'h2);
    init_write(12'h008, 32'h3);
    init_write(12'h010, 32'h80FF_7F01);
    mem_write = 1'b0;
    dbg(12'h004, "init_4", 32'h2);
    dbg(12'h000, "init_0", 32'h1);
    dbg(12'h008, "init_8", 32'h3);

    init_done = 1'b1;
    @(negedge clk);
    alu_op(ALU_ADD, 32'd0, 32'd1, 32'hC, 1'b1);
    func3 = F3_W; mem_write = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1 mem_write = 1'b0;
    dbg(12'h00C, "sw_c", 32'h1);
    load_chk(32'hC, F3_W, "lw_c", 32'h1, 1'b1);

    load_chk(32'h13, F3_B,  "lb3",  32'hFFFF_FF80, 1'b1);
    load_chk(32'h13, F3_BU, "lbu3", 32'h0000_0080, 1'b1);
    load_chk(32'h12, F3_H,  "lh2",  32'hFFFF_80FF, 1'b1);
    load_chk(32'h12, F3_HU, "lhu2", 32'h0000_80FF, 1'b1);
    load_chk(32'h10, F3_H,  "lh0",  32'h0000_7F01, 1'b1);
    load_chk(32'h10, F3_W,  "lw10", 32'h80FF_7F01, 1'b1);

    store(32'h11, F3_B, 32'h1234_56AB);
    dbg(12'h010, "sb1", 32'h80FF_AB01);
    store(32'h12, F3_H, 32'h0000_BEEF);
    dbg(12'h010, "sh2", 32'hBEEF_AB01);
    load_chk(32'h1010, F3_W, "lw_wrap", 32'hBEEF_AB01, 1'b1);

    load_chk(32'h2, F3_W, "lw_mis", 32'h0, 1'b0);
    load_chk(32'h11, F3_H, "lh_mis", 32'h0, 1'b0);
    load_chk(32'h0, 3'b011, "f3_011", 32'h0, 1'b0);
    load_chk(32'h0, 3'b110, "f3_110", 32'h0, 1'b0);
    store(32'h2, F3_W, 32'hDEAD_BEEF);
    dbg(12'h000, "sw_mis", 32'h1);

    @(negedge clk);
    mem_op(32'h0, F3_W, 1'b0, 1'b0, 32'h0);
    expect_out(S_WB, "noread_wb", 32'h0);
    expect_out(S_VALID, "noread_valid", 32'h0);
    drain();

    @(negedge clk);
    mem_op(32'hC, F3_W, 1'b1, 1'b1, 32'h55);
    expect_out(S_WB, "rw_old", 32'h1);
    drain();
    @(posedge clk);
    expect_out(S_WB, "rw_new", 32'h55);
    drain();

    @(negedge clk);
    rst = 1'b0;
    mem_op(32'hC, F3_W, 1'b1, 1'b1, 32'h77);
    expect_out(S_VALID, "rst_wr_valid", 32'h0);
    expect_out(S_WB, "rst_wr_wb", 32'h0);
    drain();
    @(posedge clk);
    #1;
    @(negedge clk);
    mem_write = 1'b0; rst = 1'b1;
    dbg(12'h00C, "rst_kept_c", 32'h55);
    load_chk(32'h0, F3_W, "rst_kept_0", 32'h1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
